// File: rtl/mem_arbiter.sv
// Round-robin arbiter giving two requesters fixed-latency access to a
// single-port synchronous memory; each grant runs IDLE -> ACCESS -> CAPTURE.
module mem_arbiter #(
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0,
    input  logic                  we0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] wdata0,
    output logic                  ack0,
    output logic [DATA_WIDTH-1:0] rdata0,
    input  logic                  req1,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  ack1,
    output logic [DATA_WIDTH-1:0] rdata1,
    input  logic [DATA_WIDTH-1:0] mem_in,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  busy,
    output logic                  gnt_id
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    state_t state;
    logic   last_served;
    logic   cur_we;
    logic   elig0;
    logic   elig1;
    logic   win;

    // A requester whose ack is showing this cycle is still holding a stale req.
    always_comb begin
        elig0 = req0 & ~ack0;
        elig1 = req1 & ~ack1;
        win   = (elig0 & elig1) ? ~last_served : elig1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ack0        <= 1'b0;
            ack1        <= 1'b0;
            rdata0      <= '0;
            rdata1      <= '0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_data    <= '0;
            busy        <= 1'b0;
            gnt_id      <= 1'b0;
            last_served <= 1'b1;
            cur_we      <= 1'b0;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            case (state)
                IDLE: begin
                    mem_we <= 1'b0;
                    busy   <= 1'b0;
                    if (elig0 | elig1) begin
                        mem_addr    <= win ? addr1 : addr0;
                        mem_data    <= win ? wdata1 : wdata0;
                        mem_we      <= win ? we1 : we0;
                        cur_we      <= win ? we1 : we0;
                        gnt_id      <= win;
                        last_served <= win;
                        busy        <= 1'b1;
                        state       <= ACCESS;
                    end
                end
                ACCESS: begin
                    mem_we <= 1'b0;
                    busy   <= 1'b1;
                    state  <= CAPTURE;
                end
                CAPTURE: begin
                    // Writes leave the requester's last read data untouched.
                    if (gnt_id) begin
                        ack1 <= 1'b1;
                        if (!cur_we) rdata1 <= mem_in;
                    end else begin
                        ack0 <= 1'b1;
                        if (!cur_we) rdata0 <= mem_in;
                    end
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    mem_we <= 1'b0;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios then random traffic, all checked
// every cycle against a transaction-timeline reference model.
module tb_mem_arbiter;

    localparam int unsigned AW    = 6;
    localparam int unsigned DW    = 16;
    localparam int unsigned DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0, we0, req1, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          ack0, ack1;
    logic [DW-1:0] rdata0, rdata1;
    logic [DW-1:0] mem_in;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic          busy, gnt_id;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
        .mem_in(mem_in), .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
        .busy(busy), .gnt_id(gnt_id)
    );

    // Synchronous single-port memory: read data valid the cycle after the address.
    logic [DW-1:0] mem [0:DEPTH-1] = '{default: '0};
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_data;
        mem_in <= mem[mem_addr];
    end

    // Reference model: one transaction at a time, granted at cycle g, acked at g+3.
    int            n_cmp = 0;
    int            n_err = 0;
    int            cyc = 0;
    int            g_cyc;
    int            ack_cyc [2];
    logic          g_id, g_we, last_srv;
    logic [DW-1:0] g_rd;
    logic [DW-1:0] exp_rd [2];
    logic [AW-1:0] exp_ma;
    logic [DW-1:0] exp_md;
    logic [DW-1:0] shadow [0:DEPTH-1] = '{default: '0};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        g_cyc      = -100;
        ack_cyc[0] = -1;
        ack_cyc[1] = -1;
        g_id       = 1'b0;
        g_we       = 1'b0;
        g_rd       = '0;
        last_srv   = 1'b1;
        exp_rd[0]  = '0;
        exp_rd[1]  = '0;
        exp_ma     = '0;
        exp_md     = '0;
    endtask

    // Check this cycle's outputs, predict the decision taken at the coming edge, advance.
    task automatic tick();
        logic e0, e1, w;
        logic [AW-1:0] a;
        for (int i = 0; i < 2; i++)
            if (ack_cyc[i] == cyc && !g_we) exp_rd[i] = g_rd;
        chk("ack0", 32'(ack0), 32'(ack_cyc[0] == cyc));
        chk("ack1", 32'(ack1), 32'(ack_cyc[1] == cyc));
        chk("busy", 32'(busy), 32'(cyc == g_cyc + 1 || cyc == g_cyc + 2));
        chk("mem_we", 32'(mem_we), 32'(cyc == g_cyc + 1 && g_we));
        chk("gnt_id", 32'(gnt_id), 32'(g_id));
        chk("mem_addr", 32'(mem_addr), 32'(exp_ma));
        chk("mem_data", 32'(mem_data), 32'(exp_md));
        chk("rdata0", 32'(rdata0), 32'(exp_rd[0]));
        chk("rdata1", 32'(rdata1), 32'(exp_rd[1]));
        if (!rst && cyc >= g_cyc + 3) begin
            e0 = req0 && (ack_cyc[0] != cyc);
            e1 = req1 && (ack_cyc[1] != cyc);
            if (e0 || e1) begin
                if (e0 && e1) w = !last_srv;
                else          w = e1;
                a          = w ? addr1 : addr0;
                g_cyc      = cyc;
                g_id       = w;
                last_srv   = w;
                g_we       = w ? we1 : we0;
                exp_ma     = a;
                exp_md     = w ? wdata1 : wdata0;
                g_rd       = shadow[a];
                if (g_we) shadow[a] = exp_md;
                ack_cyc[w] = cyc + 3;
            end
        end
        @(posedge clk);
        cyc++;
        if (rst) model_reset();
        @(negedge clk);
    endtask

    task automatic drive(input int i, input logic r, input logic w,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (i == 0) begin req0 = r; we0 = w; addr0 = a; wdata0 = d; end
        else        begin req1 = r; we1 = w; addr1 = a; wdata1 = d; end
    endtask

    task automatic drive_off(input int i);
        if (i == 0) req0 = 1'b0;
        else        req1 = 1'b0;
    endtask

    function automatic logic ack_of(input int i);
        return (i == 0) ? ack0 : ack1;
    endfunction

    function automatic logic req_of(input int i);
        return (i == 0) ? req0 : req1;
    endfunction

    // Raise req and wait (bounded) for its ack; returns in the ack cycle with req still high.
    task automatic do_txn(input int i, input logic w, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, output int lat,
                          output logic [DW-1:0] rd, output int we_cnt);
        drive(i, 1'b1, w, a, d);
        lat = -1;
        we_cnt = 0;
        rd = '0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (mem_we) we_cnt++;
            if (ack_of(i)) begin
                lat = k + 1;
                rd = (i == 0) ? rdata0 : rdata1;
                break;
            end
        end
        if (lat < 0) chk("ack_timeout", 32'(0), 32'(1));
    endtask

    task automatic finish_txn(input int i);
        tick();
        drive_off(i);
    endtask

    initial begin
        int            lat, wc, cnt;
        logic [DW-1:0] rd;
        int            q_id [$];
        int            q_cyc [$];
        bit            act [2];

        rst = 1'b1;
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        model_reset();
        rst = 1'b0;

        // Reset then idle
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_gnt", 32'(gnt_id), 32'(0));
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (mem_we) cnt++;
        end
        chk("idle_we_cnt", 32'(cnt), 32'(0));

        // Single write then read back
        do_txn(0, 1'b1, 6'h05, 16'hBEEF, lat, rd, wc);
        chk("wr_lat", 32'(lat), 32'(3));
        chk("wr_we_cnt", 32'(wc), 32'(1));
        finish_txn(0);
        do_txn(0, 1'b0, 6'h05, 16'h0000, lat, rd, wc);
        chk("rd_lat", 32'(lat), 32'(3));
        chk("rd_data", 32'(rd), 32'(16'hBEEF));
        chk("rd_we_cnt", 32'(wc), 32'(0));
        finish_txn(0);

        // Contention after reset: strict alternation starting with requester 0
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(0, 1'b1, 1'b0, 6'h05, '0);
        drive(1, 1'b1, 1'b0, 6'h07, '0);
        for (int k = 0; k < 13; k++) begin
            tick();
            chk("no_dual_ack", 32'(ack0 && ack1), 32'(0));
            if (ack0) begin q_id.push_back(0); q_cyc.push_back(cyc); end
            if (ack1) begin q_id.push_back(1); q_cyc.push_back(cyc); end
        end
        drive_off(0);
        drive_off(1);
        chk("rr_count", 32'(q_id.size() >= 4), 32'(1));
        for (int k = 0; k < 4 && k < q_id.size(); k++) begin
            chk("rr_order", 32'(q_id[k]), 32'(k % 2));
            if (k > 0) chk("rr_gap", 32'(q_cyc[k] - q_cyc[k-1]), 32'(3));
        end
        repeat (6) tick();

        // Stale req held through the ack cycle and one more
        do_txn(1, 1'b0, 6'h05, '0, lat, rd, wc);
        chk("stale_lat", 32'(lat), 32'(3));
        tick();
        chk("stale_no_regrant", 32'(busy), 32'(0));
        tick();
        drive_off(1);
        chk("stale_next_grant", 32'(busy), 32'(1));
        cnt = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (ack1) cnt++;
        end
        chk("stale_one_txn", 32'(cnt), 32'(1));

        // A write leaves rdata untouched
        do_txn(1, 1'b1, 6'h09, 16'h1234, lat, rd, wc);
        finish_txn(1);
        do_txn(1, 1'b0, 6'h09, '0, lat, rd, wc);
        chk("rd1_data", 32'(rd), 32'(16'h1234));
        finish_txn(1);
        do_txn(1, 1'b1, 6'h0A, 16'h5555, lat, rd, wc);
        chk("wr_keeps_rdata", 32'(rd), 32'(16'h1234));
        finish_txn(1);

        // Reset during CAPTURE of a read aborts it
        drive(0, 1'b1, 1'b0, 6'h05, '0);
        tick();
        tick();
        rst = 1'b1;
        drive_off(0);
        tick();
        rst = 1'b0;
        chk("abort_ack0", 32'(ack0), 32'(0));
        chk("abort_rdata0", 32'(rdata0), 32'(0));
        chk("abort_busy", 32'(busy), 32'(0));
        cnt = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (ack0) cnt++;
        end
        chk("abort_no_ack", 32'(cnt), 32'(0));
        do_txn(1, 1'b0, 6'h05, '0, lat, rd, wc);
        chk("post_abort_lat", 32'(lat), 32'(3));
        chk("post_abort_data", 32'(rd), 32'(16'hBEEF));
        finish_txn(1);

        // Random traffic from two independent requesters with occasional reset
        act[0] = 1'b0;
        act[1] = 1'b0;
        for (int n = 0; n < 1500; n++) begin
            rst = ($urandom_range(0, 299) == 0);
            for (int i = 0; i < 2; i++) begin
                if (act[i]) begin
                    if (ack_of(i)) act[i] = 1'b0;
                end else if (req_of(i)) begin
                    if ($urandom_range(0, 3) != 0) drive_off(i);
                end else if ($urandom_range(0, 2) == 0) begin
                    act[i] = 1'b1;
                    drive(i, 1'b1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), DW'($urandom));
                end
            end
            tick();
        end

        rst = 1'b0;
        drive_off(0);
        drive_off(1);
        repeat (6) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
